booth_operand_regs: RTL and testbench

Parametrised operand capture and shift stage for the signed Booth multiplier datapath. It accepts a multiplicand/multiplier pair through a valid/ready handshake and converts each operand from sign-magnitude to two's complement when configured to do so. It holds M and -M, sign-extended, for the add/subtract unit, and shifts the multiplier register (Q, Q-1) under controller command. It counts the shifts, flags the final one, and frees itself for the next pair.

---
 rtl/booth_operand_regs_pkg.sv | 20 ++
 rtl/booth_operand_regs_if.sv | 24 ++
 rtl/booth_operand_regs_convert.sv | 12 +
 rtl/booth_operand_regs.sv | 55 +++++
 tb/tb_booth_operand_regs.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/booth_operand_regs_pkg.sv
// booth_pkg: shared types and sign-magnitude/two's-complement conversion for the Booth operand stage
package booth_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int CNT_W = $clog2(DEF_WIDTH + 2);
  localparam int MAX_W = 32;
  localparam int IW = $clog2(MAX_W + 2);
  // Works at MAX_W and lets callers truncate, so one function serves every WIDTH <= MAX_W
  function automatic logic [MAX_W+1:0] sm_to_tc(input logic [MAX_W:0] d, input int w, input logic sm_in);
    logic [MAX_W+1:0] dx, mag, ext;
    logic s;
    dx = {1'b0, d};
    s = dx[IW'(w)];
    for (int i = 0; i < MAX_W + 2; i++) begin
      mag[IW'(i)] = (i < w) && dx[IW'(i)];
      ext[IW'(i)] = (i <= w) ? dx[IW'(i)] : s;
    end
    return sm_in ? (s ? -mag : mag) : ext;
  endfunction
endpackage

// File: rtl/booth_operand_regs_if.sv
// booth_operand_regs_if: operand handshake, shift control and datapath outputs of the Booth operand stage
interface booth_operand_regs_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   in_data_m;
  logic [WIDTH:0]   in_data_q;
  logic             shift_en;
  logic             shift_in;
  logic [WIDTH+1:0] o_m;
  logic [WIDTH+1:0] o_m_neg;
  logic [WIDTH:0]   o_q;
  logic             o_q_m1;
  logic [1:0]       o_booth_op;
  logic             o_busy;
  logic             o_last;
  modport master(
    output in_valid, in_data_m, in_data_q, shift_en, shift_in,
    input  in_ready, o_m, o_m_neg, o_q, o_q_m1, o_booth_op, o_busy, o_last
  );
  modport slave(
    input  in_valid, in_data_m, in_data_q, shift_en, shift_in,
    output in_ready, o_m, o_m_neg, o_q, o_q_m1, o_booth_op, o_busy, o_last
  );
endinterface

// File: rtl/booth_operand_regs_convert.sv
// operand_convert: maps one WIDTH+1 bit operand to WIDTH+2 bit two's complement
module operand_convert
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit SM_IN = 1'b1
) (
  input  logic [WIDTH:0]   d,
  output logic [WIDTH+1:0] y
);
  assign y = (WIDTH + 2)'(sm_to_tc((MAX_W + 1)'(d), WIDTH, SM_IN));
endmodule

// File: rtl/booth_operand_regs.sv
// booth_operand_regs: captures a Booth operand pair, holds M and -M, and shifts Q/Q-1 under controller command
module booth_operand_regs
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit SM_IN = 1'b1
) (
  input logic              i_clk,
  input logic              i_rst_n,
  input logic              i_clr,
  booth_operand_regs_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 2);
  state_t state_q, state_d;
  logic [WIDTH+1:0] m_q, m_d, m_conv, q_conv;
  logic [WIDTH:0] q_q, q_d;
  logic q_m1_q, q_m1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic load, shift, last;
  operand_convert #(.WIDTH(WIDTH), .SM_IN(SM_IN)) u_conv_m (.d(bus.in_data_m), .y(m_conv));
  operand_convert #(.WIDTH(WIDTH), .SM_IN(SM_IN)) u_conv_q (.d(bus.in_data_q), .y(q_conv));
  assign load  = bus.in_valid && (state_q == IDLE);
  assign shift = bus.shift_en && (state_q == BUSY);
  assign last  = shift && (cnt_q == CW'(WIDTH));
  always_comb begin
    state_d = i_clr ? IDLE : load ? BUSY : last ? IDLE : state_q;
    m_d     = i_clr ? '0 : load ? m_conv : m_q;
    q_d     = i_clr ? '0 : load ? (WIDTH + 1)'(q_conv) : shift ? {bus.shift_in, q_q[WIDTH:1]} : q_q;
    q_m1_d  = i_clr || load ? 1'b0 : shift ? q_q[0] : q_m1_q;
    cnt_d   = i_clr || load ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q_m1_q  <= q_m1_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.o_busy     = (state_q == BUSY);
  assign bus.o_last     = last;
  assign bus.o_m        = m_q;
  assign bus.o_m_neg    = -m_q;
  assign bus.o_q        = q_q;
  assign bus.o_q_m1     = q_m1_q;
  assign bus.o_booth_op = {q_q[0], q_m1_q};
endmodule

// File: tb/tb_booth_operand_regs.sv
// tb_booth_operand_regs: directed checks of load, shift, abort and reset for sign-magnitude and two's complement inputs
`timescale 1ns/100ps
module tb_booth_operand_regs;
  logic clk, rst_n, clr;
  int checks = 0;
  int errors = 0;
  booth_operand_regs_if #(.WIDTH(4)) bus0();
  booth_operand_regs_if #(.WIDTH(4)) bus1();
  booth_operand_regs #(.WIDTH(4), .SM_IN(1'b1)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(bus0.slave));
  booth_operand_regs #(.WIDTH(4), .SM_IN(1'b0)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .bus(bus1.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [4:0] m, input logic [4:0] q);
    bus0.in_valid = v;
    bus0.in_data_m = m;
    bus0.in_data_q = q;
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus0.in_ready), 1);
    chk({tag, "_busy"}, 32'(bus0.o_busy), 0);
    chk({tag, "_m"}, 32'(bus0.o_m), 0);
    chk({tag, "_mneg"}, 32'(bus0.o_m_neg), 0);
    chk({tag, "_q"}, 32'(bus0.o_q), 0);
    chk({tag, "_qm1"}, 32'(bus0.o_q_m1), 0);
    chk({tag, "_op"}, 32'(bus0.o_booth_op), 0);
    chk({tag, "_last"}, 32'(bus0.o_last), 0);
  endtask
  initial begin
    logic [4:0] exp_q [5];
    logic       exp_m1 [5];
    exp_q  = '{5'b00010, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
    exp_m1 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    rst_n = 1'b0;
    clr = 1'b0;
    drive(1'b0, 5'd0, 5'd0);
    bus0.shift_en = 1'b0;
    bus0.shift_in = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_data_m = 5'd0;
    bus1.in_data_q = 5'd0;
    bus1.shift_en = 1'b0;
    bus1.shift_in = 1'b0;
    #3;
    chk_idle_zero("reset");
    #9;
    rst_n = 1'b1;
    // load M=-3, Q=+5 in sign-magnitude
    drive(1'b1, 5'b10011, 5'b00101);
    tick();
    drive(1'b0, 5'd0, 5'd0);
    chk("ld_m", 32'(bus0.o_m), 32'h3D);
    chk("ld_mneg", 32'(bus0.o_m_neg), 32'h03);
    chk("ld_q", 32'(bus0.o_q), 32'h05);
    chk("ld_qm1", 32'(bus0.o_q_m1), 0);
    chk("ld_op", 32'(bus0.o_booth_op), 2);
    chk("ld_busy", 32'(bus0.o_busy), 1);
    chk("ld_ready", 32'(bus0.in_ready), 0);
    // five shifts; a pair offered mid-operation must be ignored, one held from the last shift is taken next
    for (int k = 0; k < 5; k++) begin
      bus0.shift_en = 1'b1;
      if (k == 1) drive(1'b1, 5'b00111, 5'b01111);
      else if (k == 4) drive(1'b1, 5'b00010, 5'b10011);
      else drive(1'b0, 5'd0, 5'd0);
      #1;
      chk($sformatf("sh%0d_last", k), 32'(bus0.o_last), (k == 4) ? 1 : 0);
      tick();
      chk($sformatf("sh%0d_q", k), 32'(bus0.o_q), 32'(exp_q[k]));
      chk($sformatf("sh%0d_qm1", k), 32'(bus0.o_q_m1), 32'(exp_m1[k]));
    end
    bus0.shift_en = 1'b0;
    chk("done_ready", 32'(bus0.in_ready), 1);
    chk("done_busy", 32'(bus0.o_busy), 0);
    chk("done_m", 32'(bus0.o_m), 32'h3D);
    tick();
    drive(1'b0, 5'd0, 5'd0);
    chk("b2b_busy", 32'(bus0.o_busy), 1);
    chk("b2b_m", 32'(bus0.o_m), 32'h02);
    chk("b2b_mneg", 32'(bus0.o_m_neg), 32'h3E);
    chk("b2b_q", 32'(bus0.o_q), 32'h1D);
    chk("b2b_op", 32'(bus0.o_booth_op), 2);
    // abort after two shifts, with a shift requested on the clear edge
    bus0.shift_en = 1'b1;
    tick();
    tick();
    chk("ab_q2", 32'(bus0.o_q), 32'h07);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus0.shift_en = 1'b0;
    chk_idle_zero("abort");
    clr = 1'b1;
    drive(1'b1, 5'b00101, 5'b00011);
    tick();
    clr = 1'b0;
    drive(1'b0, 5'd0, 5'd0);
    chk_idle_zero("clr_idle");
    bus0.shift_en = 1'b1;
    bus0.shift_in = 1'b1;
    tick();
    chk("idle_shift_q", 32'(bus0.o_q), 0);
    chk("idle_shift_busy", 32'(bus0.o_busy), 0);
    bus0.shift_en = 1'b0;
    // negative zero and most-negative operand
    drive(1'b1, 5'b10000, 5'b00000);
    bus1.in_valid = 1'b1;
    bus1.in_data_m = 5'b10000;
    tick();
    drive(1'b0, 5'd0, 5'd0);
    bus1.in_valid = 1'b0;
    chk("nz_m", 32'(bus0.o_m), 0);
    chk("nz_mneg", 32'(bus0.o_m_neg), 0);
    chk("tc_m", 32'(bus1.o_m), 32'h30);
    chk("tc_mneg", 32'(bus1.o_m_neg), 32'h10);
    bus0.shift_en = 1'b1;
    bus0.shift_in = 1'b1;
    tick();
    bus0.shift_en = 1'b0;
    bus0.shift_in = 1'b0;
    chk("shin_q", 32'(bus0.o_q), 32'h10);
    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_zero("areset");
    chk("areset_tc_m", 32'(bus1.o_m), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'b00110, 5'b10001);
    tick();
    drive(1'b0, 5'd0, 5'd0);
    chk("post_m", 32'(bus0.o_m), 32'h06);
    chk("post_mneg", 32'(bus0.o_m_neg), 32'h3A);
    chk("post_q", 32'(bus0.o_q), 32'h1F);
    chk("post_op", 32'(bus0.o_booth_op), 2);
    chk("post_busy", 32'(bus0.o_busy), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
